// File: rtl/gh_shift_reg_bd_pl.sv
// Bidirectional shift register with parallel load, runtime word length,
// remaining-bit counter and end-of-word pulse; shared by the UART TX and RX paths.
module gh_shift_reg_bd_pl #(
    parameter int size = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         srst,
    input  logic                         load,
    input  logic [size-1:0]              pd,
    input  logic [$clog2(size+1)-1:0]    wlen,
    input  logic                         dir,
    input  logic                         se,
    input  logic                         d,
    output logic [size-1:0]              q,
    output logic [size-1:0]              qa,
    output logic                         so,
    output logic [$clog2(size+1)-1:0]    cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int cw = $clog2(size+1);

    logic [size-1:0] iq_q, iq_d;
    logic [cw-1:0]   wl_q, wl_d;
    logic [cw-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [size-1:0] ones;
    logic [size-1:0] sel_onehot;
    logic [size-1:0] mask;

    // Out-of-range word lengths fall back to the full register width.
    function automatic logic [cw-1:0] clamp(input logic [cw-1:0] x);
        if (x == '0 || int'(x) > size)
            return cw'(size);
        else
            return x;
    endfunction

    always_comb begin
        iq_d   = iq_q;
        wl_d   = wl_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (srst) begin
            iq_d  = '0;
            cnt_d = '0;
            wl_d  = clamp(wlen);
        end else if (load) begin
            iq_d  = pd;
            cnt_d = clamp(wlen);
            wl_d  = clamp(wlen);
        end else if (se) begin
            if (dir)
                iq_d = {iq_q[size-2:0], d};
            else
                iq_d = {d, iq_q[size-1:1]};
            if (cnt_q != '0) begin
                cnt_d  = cnt_q - cw'(1);
                done_d = (cnt_q == cw'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq_q   <= '0;
            wl_q   <= cw'(size);
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            iq_q   <= iq_d;
            wl_q   <= wl_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // MSB-first output taps bit wl-1; wl is always 1..size so the shift is in range.
    always_comb begin
        ones       = '1;
        sel_onehot = {{(size-1){1'b0}}, 1'b1} << (wl_q - cw'(1));
        mask       = ~(ones << wl_q);
        so         = dir ? |(iq_q & sel_onehot) : iq_q[0];
        qa         = dir ? (iq_q & mask) : (iq_q >> (cw'(size) - wl_q));
    end

    assign q    = iq_q;
    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);
    assign done = done_q;

endmodule
